lsu_mem_master: RTL and testbench

Load/store unit that drives the word-wide data memory: single-cycle asynchronous read, write on posedge when WE, word index taken from addr[7:2].
- Accepts RV32 load/store requests from the execute stage and drives the memory's addr, write_data and WE.
- Performs byte/half extraction with sign/zero extension for loads.
- Performs read-modify-write for SB/SH, because the memory has only a whole-word WE.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_load_align.sv | 29 ++
 rtl/lsu_mem_master.sv | 145 ++++++++++++++
 tb/tb_lsu_mem_master.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32 width codes, FSM states and request legality helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WRITE,
        RESP
    } state_t;

    // Unsigned widths exist only for loads, so a store with BU/HU is illegal.
    function automatic logic is_illegal(input logic we, input logic [2:0] funct3);
        logic bad;
        case (funct3)
            F3_B, F3_H, F3_W: bad = 1'b0;
            F3_BU, F3_HU:     bad = we;
            default:          bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        logic bad;
        if (funct3[1:0] == 2'b01)
            bad = addr_lo[0];
        else if (funct3 == F3_W)
            bad = |addr_lo;
        else
            bad = 1'b0;
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane extraction: picks the byte/half lane from the memory word and sign/zero extends it.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    output logic [XLEN-1:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[{addr_lo_i, 3'b000} +: 8];
        half_sel = addr_lo_i[1] ? word_i[16 +: 16] : word_i[0 +: 16];
        case (funct3_i)
            F3_B:    result_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_BU:   result_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_H:    result_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_HU:   result_o = {{(XLEN-16){1'b0}}, half_sel};
            F3_W:    result_o = word_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_master.sv
// RV32 load/store unit driving a word-wide memory; SB/SH go through a read-modify-write cycle.
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic              mem_we,
    input  logic [XLEN-1:0]   mem_rdata
);

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   merge_q, merge_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              req_fault;
    logic [XLEN-1:0]   load_result;
    logic [XLEN-1:0]   merge_word;

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_fault = is_illegal(req_we, req_funct3) || is_misaligned(req_funct3, req_addr[1:0]);
`else
    assign req_fault = is_illegal(req_we, req_funct3);
`endif

    assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};

    lsu_load_align #(
        .XLEN(XLEN)
    ) u_load_align (
        .word_i   (mem_rdata),
        .funct3_i (funct3_q),
        .addr_lo_i(addr_q[1:0]),
        .result_o (load_result)
    );

    // funct3 bit 0 separates SH from SB; only those two reach the merge path.
    always_comb begin
        merge_word = mem_rdata;
        if (funct3_q[0])
            merge_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        else
            merge_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = '0;
        resp_err   = 1'b0;
        mem_we     = 1'b0;
        mem_wdata  = '0;

        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = '0;
                    err_d    = req_fault;
                    state_d  = req_fault ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                if (!we_q) begin
                    rdata_d = load_result;
                    state_d = RESP;
                end else if (funct3_q == F3_W) begin
                    mem_we    = 1'b1;
                    mem_wdata = wdata_q;
                    state_d   = RESP;
                end else begin
                    merge_d = merge_word;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_wdata = merge_q;
                state_d   = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merge_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Self-checking bench for lsu_mem_master: word memory responder plus a byte-lane reference model of the RV32 load/store rules.
module tb_lsu_mem_master;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] data_mem [64];
    logic [31:0] ref_mem  [64];

    int tests_run;
    int tests_failed;

    lsu_mem_master #(
        .ADDR_W(32),
        .XLEN  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_funct3(req_funct3),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .resp_valid(resp_valid),
        .resp_rdata(resp_rdata),
        .resp_err  (resp_err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign mem_rdata = data_mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we)
            data_mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Reference behaviour from the ISA rules: shifts and masks on whole words, two's-complement by subtraction.
    task automatic modelTransaction(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] wdata, output logic exp_err,
                                    output logic [31:0] exp_data, output int exp_lat, output int exp_we);
        logic        illegal;
        logic        misaligned;
        int          idx;
        int          bofs;
        int          hofs;
        logic [31:0] w;
        logic [31:0] mask;
        logic [31:0] lane;
        idx  = int'(addr[7:2]);
        bofs = 8 * int'(addr[1:0]);
        hofs = 16 * int'(addr[1]);
        illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (we && (f3 == 3'd4 || f3 == 3'd5));
        misaligned = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && addr[0]) misaligned = 1'b1;
        if (f3 == 3'd2 && addr[1:0] != 2'b00) misaligned = 1'b1;
`endif
        exp_data = 32'h0;
        exp_err  = 1'b0;
        exp_lat  = 2;
        exp_we   = 0;
        w = ref_mem[idx];
        if (illegal || misaligned) begin
            exp_err = 1'b1;
            exp_lat = 1;
        end else if (!we) begin
            case (f3)
                3'd0, 3'd4: begin
                    lane = (w >> bofs) & 32'hFF;
                    exp_data = (f3 == 3'd0 && lane >= 32'd128) ? lane - 32'd256 : lane;
                end
                3'd1, 3'd5: begin
                    lane = (w >> hofs) & 32'hFFFF;
                    exp_data = (f3 == 3'd1 && lane >= 32'd32768) ? lane - 32'd65536 : lane;
                end
                default: exp_data = w;
            endcase
        end else begin
            exp_we = 1;
            if (f3 == 3'd2) begin
                ref_mem[idx] = wdata;
            end else if (f3 == 3'd0) begin
                mask = 32'hFF << bofs;
                ref_mem[idx] = (w & ~mask) | ((wdata & 32'hFF) << bofs);
                exp_lat = 3;
            end else begin
                mask = 32'hFFFF << hofs;
                ref_mem[idx] = (w & ~mask) | ((wdata & 32'hFFFF) << hofs);
                exp_lat = 3;
            end
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input bit hold_valid);
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_we;
        int          cyc;
        int          we_seen;
        int          wait_n;
        bit          got;
        bit          ready_bad;
        logic [31:0] got_data;
        logic        got_err;
        modelTransaction(we, f3, addr, wdata, exp_err, exp_data, exp_lat, exp_we);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        wait_n = 0;
        while (!req_ready && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        checkOutput("accept_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        if (!hold_valid) req_valid = 1'b0;
        cyc = 1;
        got = 1'b0;
        we_seen = 0;
        ready_bad = 1'b0;
        got_data = 32'h0;
        got_err = 1'b0;
        while (!got && cyc <= 8) begin
            @(negedge clk);
            if (mem_we) we_seen++;
            if (req_ready) ready_bad = 1'b1;
            if (cyc == 1 && !exp_err) checkOutput("mem_addr", mem_addr, {addr[31:2], 2'b00});
            if (resp_valid) begin
                got = 1'b1;
                got_data = resp_rdata;
                got_err = resp_err;
            end else begin
                cyc++;
            end
        end
        checkOutput("resp_seen", 32'(got), 32'd1);
        checkOutput("resp_rdata", got_data, exp_data);
        checkOutput("resp_err", 32'(got_err), 32'(exp_err));
        checkOutput("latency", 32'(cyc), 32'(exp_lat));
        checkOutput("mem_we_count", 32'(we_seen), 32'(exp_we));
        checkOutput("ready_low_busy", 32'(ready_bad), 32'd0);
        if (!hold_valid) begin
            @(negedge clk);
            checkOutput("resp_one_cycle", 32'(resp_valid), 32'd0);
            checkOutput("ready_back", 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_funct3 = 3'd0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;

        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'h0);
        checkOutput("rst_resp_err", 32'(resp_err), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
        checkOutput("rst_mem_addr", mem_addr, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 64; i++)
            applyStimulus(1'b1, 3'd2, 32'(i * 4), $urandom, 1'b0);

        applyStimulus(1'b1, 3'd2, 32'h4, 32'hDEADBEEF, 1'b0);
        applyStimulus(1'b0, 3'd2, 32'h4, 32'h0, 1'b0);

        applyStimulus(1'b1, 3'd2, 32'h8, 32'h11223344, 1'b0);
        applyStimulus(1'b1, 3'd0, 32'h9, 32'h000000A5, 1'b0);
        checkOutput("sb_word", data_mem[2], 32'h1122A544);
        applyStimulus(1'b0, 3'd0, 32'h9, 32'h0, 1'b0);
        applyStimulus(1'b0, 3'd4, 32'h9, 32'h0, 1'b0);

        applyStimulus(1'b1, 3'd1, 32'hA, 32'h00008001, 1'b0);
        checkOutput("sh_word", data_mem[2], 32'h8001A544);
        applyStimulus(1'b0, 3'd1, 32'hA, 32'h0, 1'b0);
        applyStimulus(1'b0, 3'd5, 32'hA, 32'h0, 1'b0);

        applyStimulus(1'b0, 3'd2, 32'h6, 32'h0, 1'b0);

        // Reset lands while the SB merge word is on the write port.
        @(negedge clk);
        req_valid = 1'b1;
        req_we = 1'b1;
        req_funct3 = 3'd0;
        req_addr = 32'h8;
        req_wdata = 32'h000000FF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("we_in_write", 32'(mem_we), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("we_drop_on_rst", 32'(mem_we), 32'd0);
        checkOutput("no_resp_in_rst", 32'(resp_valid), 32'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("word_kept", data_mem[2], 32'h8001A544);
        checkOutput("no_resp_in_rst2", 32'(resp_valid), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("post_rst_ready", 32'(req_ready), 32'd1);
        checkOutput("post_rst_resp_rdata", resp_rdata, 32'h0);
        checkOutput("post_rst_resp_err", 32'(resp_err), 32'd0);
        checkOutput("post_rst_mem_wdata", mem_wdata, 32'h0);
        checkOutput("post_rst_mem_addr", mem_addr, 32'h0);

        applyStimulus(1'b0, 3'd2, 32'h4, 32'h0, 1'b1);
        applyStimulus(1'b1, 3'd0, 32'h11, 32'h0000005A, 1'b1);
        applyStimulus(1'b0, 3'd3, 32'h20, 32'h0, 1'b0);

        for (int n = 0; n < 300; n++)
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                          (n != 299) && ($urandom_range(0, 3) == 0));

        for (int i = 0; i < 64; i++)
            checkOutput("final_mem", data_mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
